// File: rtl/pt22xx_pkg.sv
// Shared PT2262/PT2272 protocol definitions: symbol codes, alpha widths,
// pulse classification limits and the two-pulse symbol decoder.
package pt22xx_pkg;

  typedef enum logic [1:0] {
    BIT_0    = 2'b00,
    BIT_1    = 2'b01,
    BIT_F    = 2'b10,
    BIT_SYNC = 2'b11
  } sym_e;

  typedef enum logic [1:0] {
    S_HUNT,
    S_RECV,
    S_CHECK,
    S_ERROR
  } dec_state_e;

  typedef struct packed {
    logic valid;
    sym_e sym;
  } sym_dec_t;

  localparam int ALPHA_SHORT = 4;
  localparam int ALPHA_LONG  = 12;
  localparam int ALPHA_SYNC  = 128;

  // Limits sit midway between nominal widths so either edge may jitter.
  localparam logic [7:0] SHORT_MIN = 8'(ALPHA_SHORT / 2);
  localparam logic [7:0] LONG_MIN  = 8'((ALPHA_SHORT + ALPHA_LONG) / 2);
  localparam logic [7:0] SHORT_MAX = LONG_MIN - 8'd1;
  localparam logic [7:0] LONG_MAX  = 8'(ALPHA_LONG + ALPHA_SHORT - 1);
  localparam logic [7:0] SYNC_MIN  = 8'(ALPHA_SYNC / 4);
  localparam logic [7:0] WIDTH_SAT = 8'hFF;

  localparam logic [3:0] NUM_SYMS = 4'd12;

  function automatic sym_dec_t decode_sym(input logic first_long, input logic second_long);
    sym_dec_t d;
    d.valid = 1'b1;
    case ({first_long, second_long})
      2'b00:   d.sym = BIT_0;
      2'b11:   d.sym = BIT_1;
      2'b01:   d.sym = BIT_F;
      default: begin d.sym = BIT_SYNC; d.valid = 1'b0; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pt2272_pulse_classifier.sv
// Synchronizes the serial waveform, measures each level in alpha units and
// emits one-cycle strobes for SHORT/LONG/ERR high pulses and SYNC_GAP lows.
module pt2272_pulse_classifier
  import pt22xx_pkg::*;
#(
  parameter int ALPHA_CLKS = 250
) (
  input  logic clk,
  input  logic reset,
  input  logic cod_i,
  output logic o_tick,
  output logic o_short,
  output logic o_long,
  output logic o_err,
  output logic o_sync
);

  localparam int PW = (ALPHA_CLKS > 1) ? $clog2(ALPHA_CLKS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(ALPHA_CLKS - 1);

  logic          r_s1, r_s2, r_lvl;
  logic [PW-1:0] r_pre;
  logic [7:0]    r_width;

  logic w_edge, w_tick, w_fall, w_is_short, w_is_long;

  assign w_edge     = r_s2 ^ r_lvl;
  assign w_tick     = !w_edge && (r_pre == PRE_LAST);
  assign w_fall     = w_edge && !r_s2;
  assign w_is_short = (r_width >= SHORT_MIN) && (r_width <= SHORT_MAX);
  assign w_is_long  = (r_width >= LONG_MIN) && (r_width <= LONG_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_lvl   <= 1'b0;
      r_pre   <= '0;
      r_width <= '0;
      o_tick  <= 1'b0;
      o_short <= 1'b0;
      o_long  <= 1'b0;
      o_err   <= 1'b0;
      o_sync  <= 1'b0;
    end else begin
      r_s1  <= cod_i;
      r_s2  <= r_s1;
      r_lvl <= r_s2;
      // Prescaler phase restarts on each edge so widths are measured from it.
      if (w_edge || w_tick) r_pre <= '0;
      else                  r_pre <= r_pre + 1'b1;
      if (w_edge)                                r_width <= '0;
      else if (w_tick && r_width != WIDTH_SAT)   r_width <= r_width + 8'd1;
      o_tick  <= w_tick;
      o_short <= w_fall && w_is_short;
      o_long  <= w_fall && w_is_long;
      o_err   <= w_fall && !w_is_short && !w_is_long;
      // Fires while the low is still in progress, once per low period.
      o_sync  <= w_tick && !r_s2 && (r_width == SYNC_MIN - 8'd1);
    end
  end

endmodule

// File: rtl/pt2272_decoder.sv
// PT2272-style decoder: assembles 12 tri-state symbols, matches the address,
// and latches data after two consecutive identical accepted frames.
module pt2272_decoder
  import pt22xx_pkg::*;
#(
  parameter int ALPHA_CLKS = 250,
  parameter int VT_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cod_i,
  input  logic [7:0] A,
  input  logic [7:0] A_F,
  output logic [3:0] D,
  output logic       vt,
  output logic       frame_err
);

  localparam int TW = $clog2(VT_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(VT_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(VT_TIMEOUT - 1);

  logic w_tick, w_short, w_long, w_err, w_sync;

  pt2272_pulse_classifier #(
    .ALPHA_CLKS(ALPHA_CLKS)
  ) u_cls (
    .clk    (clk),
    .reset  (reset),
    .cod_i  (cod_i),
    .o_tick (w_tick),
    .o_short(w_short),
    .o_long (w_long),
    .o_err  (w_err),
    .o_sync (w_sync)
  );

  dec_state_e       r_state, w_state_nxt;
  logic [3:0]       r_idx;
  logic             r_half, r_first_long, r_tail;
  logic [11:0][1:0] r_sym;
  logic [1:0]       r_cnt;
  logic [3:0]       r_prev_data;
  logic [TW-1:0]    r_to;

  logic     w_first, w_store, w_tail, w_clr;
  sym_dec_t w_dec;
  logic     w_ok;
  logic [3:0] w_data;
  logic [1:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_HUNT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_first     = 1'b0;
    w_store     = 1'b0;
    w_tail      = 1'b0;
    w_clr       = 1'b0;
    w_dec       = decode_sym(r_first_long, w_long);
    case (r_state)
      S_HUNT: if (w_sync) begin
        w_state_nxt = S_RECV;
        w_clr       = 1'b1;
      end
      S_RECV: begin
        if (r_idx < NUM_SYMS) begin
          if (w_sync || w_err) w_state_nxt = S_ERROR;
          else if (w_short || w_long) begin
            if (!r_half)           w_first     = 1'b1;
            else if (!w_dec.valid) w_state_nxt = S_ERROR;
            else                   w_store     = 1'b1;
          end
        end else begin
          // After the 12 symbols only the sync bit (short high, long low) may follow.
          if (w_sync)                    w_state_nxt = r_tail ? S_CHECK : S_ERROR;
          else if (w_short && !r_tail)   w_tail      = 1'b1;
          else if (w_short || w_long || w_err) w_state_nxt = S_ERROR;
        end
      end
      S_CHECK: begin
        w_state_nxt = S_RECV;
        w_clr       = 1'b1;
      end
      default: begin
        w_state_nxt = S_HUNT;
        w_clr       = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_ok   = 1'b1;
    w_data = '0;
    for (int i = 0; i < 8; i++) begin
      if (A_F[i]) begin
        if (r_sym[i] != BIT_F) w_ok = 1'b0;
      end else if (r_sym[i] != {1'b0, A[i]}) begin
        w_ok = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (r_sym[8+i][1]) w_ok = 1'b0;
      w_data[i] = r_sym[8+i][0];
    end
    if (r_cnt != 2'd0 && w_data == r_prev_data)
      w_cnt_nxt = (r_cnt == 2'd3) ? 2'd3 : r_cnt + 2'd1;
    else
      w_cnt_nxt = 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx        <= '0;
      r_half       <= 1'b0;
      r_first_long <= 1'b0;
      r_tail       <= 1'b0;
      r_sym        <= '0;
      r_cnt        <= '0;
      r_prev_data  <= '0;
      r_to         <= '0;
      D            <= 4'h0;
      vt           <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (w_clr) begin
        r_idx  <= '0;
        r_half <= 1'b0;
        r_tail <= 1'b0;
      end
      if (w_first) begin
        r_half       <= 1'b1;
        r_first_long <= w_long;
      end
      if (w_store) begin
        r_sym[r_idx] <= w_dec.sym;
        r_idx        <= r_idx + 4'd1;
        r_half       <= 1'b0;
      end
      if (w_tail) r_tail <= 1'b1;

      if (w_tick && r_to != TO_MAX) r_to <= r_to + 1'b1;
      if (w_tick && r_to == TO_LAST) begin
        vt    <= 1'b0;
        r_cnt <= '0;
      end

      if (r_state == S_ERROR) begin
        frame_err <= 1'b1;
        r_cnt     <= '0;
      end
      // Frame verdict; an accepted frame wins over a coincident timeout.
      if (r_state == S_CHECK) begin
        if (!w_ok) begin
          frame_err <= 1'b1;
          r_cnt     <= '0;
        end else begin
          r_cnt       <= w_cnt_nxt;
          r_prev_data <= w_data;
          r_to        <= '0;
          if (w_cnt_nxt >= 2'd2) begin
            D  <= w_data;
            vt <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pt2272_decoder.sv
// Directed bench for pt2272_decoder: encodes PT2262 frames on cod_i and
// checks vt/D/frame_err against hand-derived expectations.
module tb_pt2272_decoder;

  localparam int AC = 4;

  logic       clk, reset, cod_i;
  logic [7:0] A, A_F;
  logic [3:0] D;
  logic       vt, frame_err;

  pt2272_decoder #(.ALPHA_CLKS(AC), .VT_TIMEOUT(1024)) dut (
    .clk(clk), .reset(reset), .cod_i(cod_i), .A(A), .A_F(A_F),
    .D(D), .vt(vt), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, errs = 0, rise_cyc = 0, fall_cyc = 0, sync_lo_cyc = 0;
  logic vt_q = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (frame_err) errs++;
    if (vt && !vt_q) rise_cyc = cyc;
    if (!vt && vt_q) fall_cyc = cyc;
    vt_q = vt;
  end

  function automatic logic [11:0][1:0] mk(input logic [7:0] a, input logic [7:0] af,
                                          input logic [3:0] d);
    logic [11:0][1:0] f;
    for (int i = 0; i < 8; i++) f[i] = af[i] ? 2'b10 : {1'b0, a[i]};
    for (int i = 0; i < 4; i++) f[8+i] = {1'b0, d[i]};
    return f;
  endfunction

  task automatic pulse(input int hi, input int lo);
    cod_i = 1'b1;
    repeat (hi * AC) @(negedge clk);
    cod_i = 1'b0;
    repeat (lo * AC) @(negedge clk);
  endtask

  // Code 2'b11 here means an illegal (LONG,SHORT) symbol.
  task automatic send_sym(input logic [1:0] s);
    case (s)
      2'b00:   begin pulse(4, 12);  pulse(4, 12);  end
      2'b01:   begin pulse(12, 4);  pulse(12, 4);  end
      2'b10:   begin pulse(4, 12);  pulse(12, 4);  end
      default: begin pulse(12, 4);  pulse(4, 12);  end
    endcase
  endtask

  task automatic send_frame(input logic [11:0][1:0] f, input bit long_sync);
    for (int i = 0; i < 12; i++) send_sym(f[i]);
    cod_i = 1'b1;
    repeat ((long_sync ? 12 : 4) * AC) @(negedge clk);
    cod_i = 1'b0;
    sync_lo_cyc = cyc;
    repeat (124 * AC) @(negedge clk);
  endtask

  task automatic do_reset(input logic [7:0] a, input logic [7:0] af);
    A = a; A_F = af; cod_i = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40 * AC) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [11:0][1:0] f;
    int e0, lat;
    do_reset(8'h3C, 8'h00);
    e0 = errs;
    f = mk(8'h3C, 8'h00, 4'hA);
    send_frame(f, 0);
    n_chk++; if (vt !== 1'b0) $display("FAIL basic_single_vt: got %b want 0", vt); else n_pass++;
    send_frame(f, 0);
    n_chk++; if (vt !== 1'b1) $display("FAIL basic_vt: got %b want 1", vt); else n_pass++;
    n_chk++; if (D !== 4'hA) $display("FAIL basic_D: got %h want a", D); else n_pass++;
    n_chk++; if (errs - e0 != 0) $display("FAIL basic_err: got %0d want 0", errs - e0); else n_pass++;
    // 32 alpha of low (128 clk) plus sync/detect/CHECK pipeline
    lat = rise_cyc - sync_lo_cyc;
    n_chk++; if (lat < 128 || lat > 140) $display("FAIL basic_latency: got %0d want 128..140", lat); else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (D !== 4'h0) $display("FAIL reset_D: got %h want 0", D); else n_pass++;
    n_chk++; if (vt !== 1'b0) $display("FAIL reset_vt: got %b want 0", vt); else n_pass++;
    n_chk++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", frame_err); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_addr_mismatch();
    int e0;
    do_reset(8'h00, 8'h00);
    e0 = errs;
    send_frame(mk(8'h01, 8'h00, 4'h3), 0);
    n_chk++; if (errs - e0 != 1) $display("FAIL mismatch_err: got %0d want 1", errs - e0); else n_pass++;
    n_chk++; if (vt !== 1'b0) $display("FAIL mismatch_vt: got %b want 0", vt); else n_pass++;
    n_chk++; if (D !== 4'h0) $display("FAIL mismatch_D: got %h want 0", D); else n_pass++;
  endtask

  task automatic test_float_addr();
    logic [11:0][1:0] f;
    int e0;
    do_reset(8'h00, 8'h81);
    e0 = errs;
    f = mk(8'h00, 8'h81, 4'hC);
    send_frame(f, 0);
    send_frame(f, 0);
    n_chk++; if (vt !== 1'b1) $display("FAIL af_vt: got %b want 1", vt); else n_pass++;
    n_chk++; if (D !== 4'hC) $display("FAIL af_D: got %h want c", D); else n_pass++;
    n_chk++; if (errs - e0 != 0) $display("FAIL af_err_ok: got %0d want 0", errs - e0); else n_pass++;
    f[7] = 2'b00;
    send_frame(f, 0);
    n_chk++; if (errs - e0 != 1) $display("FAIL af_err_bad: got %0d want 1", errs - e0); else n_pass++;
  endtask

  task automatic test_data_f();
    logic [11:0][1:0] f;
    int e0;
    do_reset(8'h3C, 8'h00);
    e0 = errs;
    f = mk(8'h3C, 8'h00, 4'h5);
    f[10] = 2'b10;
    send_frame(f, 0);
    n_chk++; if (errs - e0 != 1) $display("FAIL dataf_err: got %0d want 1", errs - e0); else n_pass++;
    n_chk++; if (vt !== 1'b0) $display("FAIL dataf_vt: got %b want 0", vt); else n_pass++;
  endtask

  task automatic test_invalid();
    logic [11:0][1:0] f, g;
    int e0;
    do_reset(8'h3C, 8'h00);
    e0 = errs;
    f = mk(8'h3C, 8'h00, 4'h1);
    g = f;
    g[3] = 2'b11;
    send_frame(g, 0);
    n_chk++; if (errs - e0 != 1) $display("FAIL invalid_sym_err: got %0d want 1", errs - e0); else n_pass++;
    send_frame(f, 1);
    n_chk++; if (errs - e0 != 2) $display("FAIL long_tail_err: got %0d want 2", errs - e0); else n_pass++;
    send_frame(f, 0);
    send_frame(f, 0);
    n_chk++; if (vt !== 1'b1) $display("FAIL recover_vt: got %b want 1", vt); else n_pass++;
    n_chk++; if (D !== 4'h1) $display("FAIL recover_D: got %h want 1", D); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset(8'h3C, 8'h00);
    send_frame(mk(8'h3C, 8'h00, 4'h5), 0);
    n_chk++; if (vt !== 1'b0) $display("FAIL seq_vt1: got %b want 0", vt); else n_pass++;
    send_frame(mk(8'h3C, 8'h00, 4'h6), 0);
    n_chk++; if (vt !== 1'b0) $display("FAIL seq_vt2: got %b want 0", vt); else n_pass++;
    send_frame(mk(8'h3C, 8'h00, 4'h6), 0);
    n_chk++; if (vt !== 1'b1) $display("FAIL seq_vt3: got %b want 1", vt); else n_pass++;
    n_chk++; if (D !== 4'h6) $display("FAIL seq_D: got %h want 6", D); else n_pass++;
  endtask

  task automatic test_timeout();
    logic [11:0][1:0] f;
    int dt;
    do_reset(8'h3C, 8'h00);
    f = mk(8'h3C, 8'h00, 4'h9);
    send_frame(f, 0);
    send_frame(f, 0);
    n_chk++; if (vt !== 1'b1) $display("FAIL to_vt_up: got %b want 1", vt); else n_pass++;
    for (int k = 0; k < 6000 && vt; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    n_chk++; if (vt !== 1'b0) $display("FAIL to_vt_down: got %b want 0", vt); else n_pass++;
    // 1024 alpha at 4 clk each, measured from the cycle vt rose
    dt = fall_cyc - rise_cyc;
    n_chk++; if (dt < 4088 || dt > 4104) $display("FAIL to_interval: got %0d want 4088..4104", dt); else n_pass++;
    n_chk++; if (D !== 4'h9) $display("FAIL to_D_hold: got %h want 9", D); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic [11:0][1:0] f;
    int e0;
    do_reset(8'h3C, 8'h00);
    e0 = errs;
    f = mk(8'h3C, 8'h00, 4'h7);
    fork
      send_frame(f, 0);
      begin
        // 5 symbols of 128 clk, then 8 clk into symbol 5's first high
        repeat (648) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
      end
    join
    send_frame(f, 0);
    n_chk++; if (vt !== 1'b0) $display("FAIL midrst_vt1: got %b want 0", vt); else n_pass++;
    send_frame(f, 0);
    n_chk++; if (vt !== 1'b1) $display("FAIL midrst_vt2: got %b want 1", vt); else n_pass++;
    n_chk++; if (D !== 4'h7) $display("FAIL midrst_D: got %h want 7", D); else n_pass++;
    n_chk++; if (errs - e0 != 0) $display("FAIL midrst_err: got %0d want 0", errs - e0); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; cod_i = 1'b0; A = 8'h00; A_F = 8'h00;
    repeat (2) @(negedge clk);
    test_basic();
    test_reset();
    test_addr_mismatch();
    test_float_addr();
    test_data_f();
    test_invalid();
    test_back_to_back();
    test_timeout();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
